// File: rtl/ins_step_sequencer.sv
// Multicycle instruction step sequencer: fetches into IR, drives the step counter,
// and tracks halt, resume, watchdog fault and the count of retired instructions.
module ins_step_sequencer #(
    parameter int IW       = 16,
    parameter int CNT_W    = 3,
    parameter int MAX_STEP = 7,
    parameter int ICNT_W   = 16
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Resume,
    input  logic [IW-1:0]     Ins_in,
    input  logic              Ins_valid,
    input  logic              Buff_PC,
    input  logic              Done,
    output logic              Ins_req,
    output logic [CNT_W-1:0]  Cnt,
    output logic [4:0]        InsM,
    output logic [1:0]        InsL,
    output logic [IW-1:0]     IR,
    output logic              Halted,
    output logic              Fault,
    output logic [ICNT_W-1:0] InsCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]       ir_q, ir_d;
    logic                req_q, req_d;
    logic                halted_q, halted_d;
    logic                fault_q, fault_d;
    logic [ICNT_W-1:0]   icnt_q, icnt_d;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            icnt_q   <= icnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        icnt_d   = icnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Start) state_d = S_FETCH;
            end
            S_FETCH: begin
                cnt_d = '0;
                if (Ins_valid) begin
                    ir_d    = Ins_in;
                    cnt_d   = CNT_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Done outranks Buff_PC; both retire the instruction exactly once.
                if (Done) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    icnt_d   = icnt_q + ICNT_W'(1);
                end else if (Buff_PC) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    icnt_d  = icnt_q + ICNT_W'(1);
                end else if (cnt_q == CNT_W'(MAX_STEP)) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALT: begin
                if (Resume) begin
                    state_d  = S_FETCH;
                    cnt_d    = '0;
                    halted_d = 1'b0;
                end
            end
            S_FAULT: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The fetch request is registered so it is high exactly while sitting in FETCH.
    assign req_d    = (state_d == S_FETCH);

    assign Ins_req  = req_q;
    assign Cnt      = cnt_q;
    assign IR       = ir_q;
    assign InsM     = ir_q[15:11];
    assign InsL     = ir_q[1:0];
    assign Halted   = halted_q;
    assign Fault    = fault_q;
    assign InsCount = icnt_q;

endmodule

// File: doc/ins_step_sequencer.md
Name: ins_step_sequencer

Overview:
Multicycle control front-end that feeds the per-instruction signal decoders (Buff_PC / Done generators).
- Requests and latches each instruction word into an instruction register (IR).
- Drives the step counter Cnt and the decoder fields InsM / InsL.
- Consumes Buff_PC (instruction retire) and Done (halt decoded) back from the decoders.
- Adds halt, resume, watchdog fault and retired-instruction counting.

Parameters:
IW, 16, instruction word width.
CNT_W, 3, step counter width.
MAX_STEP, 7, watchdog limit: highest Cnt value allowed without Buff_PC.
ICNT_W, 16, retired-instruction counter width.

Ports:
clk  input  1  system clock, rising edge.
Rst  input  1  reset, asynchronous, active-high.
Start  input  1  leave IDLE and begin fetching.
Resume  input  1  leave HALT and fetch the next instruction.
Ins_in  input  IW  instruction word from instruction memory.
Ins_valid  input  1  Ins_in valid this cycle.
Buff_PC  input  1  from Buff_PC decoder: current instruction retires this cycle.
Done  input  1  from Done decoder: current instruction is HLT.
Ins_req  output  1  instruction fetch request.
Cnt  output  CNT_W  step counter to the decoders.
InsM  output  5  IR[15:11].
InsL  output  2  IR[1:0].
IR  output  IW  full instruction register.
Halted  output  1  high in HALT.
Fault  output  1  sticky watchdog fault.
InsCount  output  ICNT_W  retired instructions, wraps modulo 2^ICNT_W.

Behaviour:
- States:
  - IDLE, FETCH, EXEC, HALT, FAULT.
  - All registers update on the rising clk edge.
  - Rst asserted at any time, including mid-instruction, forces the reset values immediately.
- Reset values: state=IDLE, Cnt=0, IR=0, Ins_req=0, Halted=0, Fault=0, InsCount=0.
  - InsM/InsL follow IR combinationally (0 at reset).
- IDLE: Cnt=0, Ins_req=0. Start=1 -> FETCH.
- FETCH:
  - Cnt=0, Ins_req=1 (registered: asserted the cycle after entering FETCH).
  - Ins_valid=0: stall, Cnt held at 0, IR unchanged.
  - Ins_valid=1: IR<=Ins_in, Cnt<=1, ->EXEC. Ins_req deasserts in the same edge.
  - Buff_PC and Done are ignored in FETCH and IDLE (IR stale).
- EXEC: Cnt>=1; Buff_PC/Done are sampled each edge with the following priority.
  1. Done=1 -> HALT. Cnt frozen at its current value, IR held, InsCount+1. Done wins over a simultaneous Buff_PC.
  2. Buff_PC=1 -> FETCH. Cnt<=0, InsCount+1.
  3. Cnt==MAX_STEP with Buff_PC=0 -> FAULT. Fault<=1, Cnt held at MAX_STEP.
  4. Otherwise Cnt<=Cnt+1. Cnt never wraps.
- HALT:
  - Halted=1, Ins_req=0, Cnt/IR frozen.
  - Resume=1 -> FETCH with Cnt<=0, Halted<=0 next edge.
  - Start is ignored.
- FAULT:
  - Fault=1, Ins_req=0, Cnt/IR frozen.
  - Exit only via Rst; Start/Resume ignored.
- Latency:
  - Ins_valid to IR/InsM/InsL updated: 1 edge.
  - Buff_PC to next Ins_req: 1 edge.
  - Minimum instruction period is 2 cycles (Cnt 0,1) with Ins_valid held high.
- InsCount increments exactly once per retired instruction (Buff_PC exit or Done exit).
  - Wraps 0xFFFF -> 0x0000.
  - Not incremented on FAULT.
- Ins_valid while not in FETCH is ignored.

Test Plan:
- Reset/start: assert Rst mid-EXEC at Cnt=3 -> Cnt=0, IR=0, state IDLE immediately. Start=1 -> Ins_req=1 one edge later.
- Fetch stall: Ins_valid low 3 cycles, then Ins_in=0x0801 (LHI) -> Cnt held 0 for 3 cycles. Then IR=0x0801, InsM=5'b00001, Cnt=1.
- Retire: Buff_PC=1 at Cnt=4 -> next edge Cnt=0, Ins_req=1, InsCount 0->1. Repeat 25 instructions -> InsCount=25.
- Halt/resume:
  - Ins_in=0xE001 (InsM=11100, InsL=01) with Done and Buff_PC both 1 at Cnt=2 -> HALT, Halted=1, Cnt stays 2, InsCount+1.
  - Resume=1 -> Cnt=0, FETCH, Halted=0.
- Watchdog: hold Buff_PC=0 from Cnt=1 -> Cnt reaches 7, next edge Fault=1. Cnt stays 7. Resume/Start ignored; only Rst clears.
- Counter wrap: preload InsCount to 0xFFFF via 65535 back-to-back 2-cycle retires -> next retire gives InsCount=0x0000.
